// File: rtl/fp_mul_result_buffer.sv
// FIFO for FP multiplier results with exception counter and optional sticky flags (FP_STICKY_FLAGS_EN).
// Latency: a pushed word reaches the outputs one cycle later (no bypass).
// Backpressure: in_ready drops when the buffer is full; out_valid and in_ready come only from registered state.

module fp_mul_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdat,
   output logic [W-1:0]             rdat,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Storage is left out of reset; only pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdat;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rdat = mem[rd_ptr];
endmodule

module fp_mul_result_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_result,
   input  logic [4:0]               in_flags,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_result,
   output logic [4:0]               out_flags,
   output logic [$clog2(DEPTH):0]   count,
   output logic [7:0]               exc_count,
   input  logic                     sticky_clr,
   output logic [4:0]               sticky
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic        push;
   logic        pop;
   logic        exc_hit;
   logic [36:0] head_dat;

   assign in_ready  = (count < FULL_CNT);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   fp_mul_fifo #(.W(37), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .wdat    ({in_result, in_flags}),
      .rdat    (head_dat),
      .count   (count)
   );

   // Outputs forced to zero when empty so stale storage never leaks out.
   assign out_result = out_valid ? head_dat[36:5] : 32'd0;
   assign out_flags  = out_valid ? head_dat[4:0]  : 5'd0;

   // zero (bit 2) is a normal result, not an exception.
   assign exc_hit = |(in_flags & 5'b11011);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exc_count <= 8'd0;
      end else if (push && exc_hit && (exc_count != 8'hff)) begin
         exc_count <= exc_count + 8'd1;
      end
   end

`ifdef FP_STICKY_FLAGS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sticky <= 5'd0;
      end else if (sticky_clr) begin
         sticky <= push ? in_flags : 5'd0;
      end else if (push) begin
         sticky <= sticky | in_flags;
      end
   end
`else
   logic unused_sticky_clr;
   assign unused_sticky_clr = sticky_clr;
   assign sticky = 5'd0;
`endif
endmodule

// File: tb/tb_fp_mul_result_buffer.sv
// Directed bench for fp_mul_result_buffer (DEPTH=4); sticky expectations follow FP_STICKY_FLAGS_EN.
module tb_fp_mul_result_buffer;
   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic [4:0]  in_flags;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_flags;
   logic [2:0]  count;
   logic [7:0]  exc_count;
   logic        sticky_clr;
   logic [4:0]  sticky;

   int checks = 0;
   int errors = 0;

   fp_mul_result_buffer #(.DEPTH(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_flags   (in_flags),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .count      (count),
      .exc_count  (exc_count),
      .sticky_clr (sticky_clr),
      .sticky     (sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 1'b0; in_result = 32'd0; in_flags = 5'd0;
      out_ready = 1'b0; sticky_clr = 1'b0;
      #12;
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ctrl: count=%0d out_valid=%b in_ready=%b, expected 0/0/1", count, out_valid, in_ready);
      end
      checks++;
      if (out_result !== 32'd0 || out_flags !== 5'd0 || exc_count !== 8'd0 || sticky !== 5'd0) begin
         errors++;
         $display("FAIL reset_data: out_result=%h out_flags=%b exc=%0d sticky=%b, expected zeros", out_result, out_flags, exc_count, sticky);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_result = 32'h40400000; in_flags = 5'b00000; out_ready = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_result !== 32'd0) begin
         errors++;
         $display("FAIL no_bypass: out_valid=%b out_result=%h, expected 0/0", out_valid, out_result);
      end
      cyc();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h40400000 || count !== 3'd1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_push: out_valid=%b out_result=%h count=%0d in_ready=%b, expected 1/40400000/1/1", out_valid, out_result, count, in_ready);
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || out_result !== 32'd0) begin
         errors++;
         $display("FAIL single_pop: count=%0d out_valid=%b out_result=%h, expected 0/0/0", count, out_valid, out_result);
      end
   endtask

   task automatic test_fill_drain();
      logic [31:0] w [4];
      logic [4:0]  f [4];
      w[0] = 32'h3f800000; w[1] = 32'h40000000; w[2] = 32'h40400000; w[3] = 32'h40800000;
      f[0] = 5'b00000;     f[1] = 5'b00000;     f[2] = 5'b00000;     f[3] = 5'b00100;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_result = w[i]; in_flags = f[i];
         cyc();
      end
      in_valid = 1'b0;
      checks++;
      if (count !== 3'd4 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full: count=%0d in_ready=%b, expected 4/0", count, in_ready);
      end
      in_valid = 1'b1; in_result = 32'hdeadbeef; in_flags = 5'b00000;
      cyc();
      checks++;
      if (count !== 3'd4 || out_result !== w[0] || out_flags !== f[0]) begin
         errors++;
         $display("FAIL full_reject: count=%0d head=%h, expected 4/%h", count, out_result, w[0]);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_result !== w[i] || out_flags !== f[i]) begin
            errors++;
            $display("FAIL drain_%0d: valid=%b result=%h flags=%b, expected 1/%h/%b", i, out_valid, out_result, out_flags, w[i], f[i]);
         end
         cyc();
         in_valid = 1'b0;
      end
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_result !== 32'd0 || out_flags !== 5'd0 || count !== 3'd0) begin
         errors++;
         $display("FAIL drained: valid=%b result=%h flags=%b count=%0d, expected 0/0/0/0", out_valid, out_result, out_flags, count);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] base;
      base = 32'h41000000;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_result = base + k; in_flags = 5'd0;
         cyc();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1; in_result = base + k + 2;
         checks++;
         if (count !== 3'd2 || out_result !== base + k) begin
            errors++;
            $display("FAIL stream_%0d: count=%0d head=%h, expected 2/%h", k, count, out_result, base + k);
         end
         cyc();
      end
      in_valid = 1'b0;
      for (int k = 10; k < 12; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_result !== base + k) begin
            errors++;
            $display("FAIL stream_tail_%0d: valid=%b head=%h, expected 1/%h", k, out_valid, out_result, base + k);
         end
         cyc();
      end
      out_ready = 1'b0;
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_empty: count=%0d valid=%b, expected 0/0", count, out_valid);
      end
   endtask

   task automatic test_exc_count();
      in_valid = 1'b1; out_ready = 1'b1; in_flags = 5'b01000; in_result = 32'h7fc00000;
      for (int i = 0; i < 300; i++) begin
         cyc();
         if (i == 9) begin
            checks++;
            if (exc_count !== 8'd10) begin
               errors++;
               $display("FAIL exc_partial: exc_count=%0d, expected 10", exc_count);
            end
         end
      end
      checks++;
      if (exc_count !== 8'd255) begin
         errors++;
         $display("FAIL exc_saturate: exc_count=%0d, expected 255", exc_count);
      end
      in_flags = 5'b00100; in_result = 32'd0;
      cyc();
      in_valid = 1'b0;
      checks++;
      if (exc_count !== 8'd255 || count !== 3'd1 || out_flags !== 5'b00100) begin
         errors++;
         $display("FAIL exc_zero: exc_count=%0d count=%0d flags=%b, expected 255/1/00100", exc_count, count, out_flags);
      end
      cyc();
      out_ready = 1'b0;
      in_flags = 5'd0;
   endtask

   task automatic test_sticky();
      logic [4:0] exp1, exp2;
`ifdef FP_STICKY_FLAGS_EN
      exp1 = 5'b10001; exp2 = 5'b00010;
`else
      exp1 = 5'b00000; exp2 = 5'b00000;
`endif
      sticky_clr = 1'b1;
      cyc();
      sticky_clr = 1'b0;
      checks++;
      if (sticky !== 5'd0) begin
         errors++;
         $display("FAIL sticky_clear: sticky=%b, expected 00000", sticky);
      end
      in_valid = 1'b1; in_result = 32'h7f800000; in_flags = 5'b10000;
      cyc();
      in_result = 32'h00000001; in_flags = 5'b00001;
      cyc();
      in_valid = 1'b0;
      checks++;
      if (sticky !== exp1) begin
         errors++;
         $display("FAIL sticky_or: sticky=%b, expected %b", sticky, exp1);
      end
      in_valid = 1'b1; sticky_clr = 1'b1; in_result = 32'h7f7fffff; in_flags = 5'b00010;
      cyc();
      in_valid = 1'b0; sticky_clr = 1'b0; in_flags = 5'd0;
      checks++;
      if (sticky !== exp2) begin
         errors++;
         $display("FAIL sticky_clr_push: sticky=%b, expected %b", sticky, exp2);
      end
   endtask

   task automatic test_async_reset();
      checks++;
      if (count !== 3'd3) begin
         errors++;
         $display("FAIL pre_reset_count: count=%0d, expected 3", count);
      end
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || out_result !== 32'd0 || exc_count !== 8'd0 || sticky !== 5'd0) begin
         errors++;
         $display("FAIL async_reset: count=%0d valid=%b result=%h exc=%0d sticky=%b, expected zeros", count, out_valid, out_result, exc_count, sticky);
      end
      @(negedge clk);
      reset_n = 1'b1;
      cyc();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL post_reset: in_ready=%b valid=%b count=%0d, expected 1/0/0", in_ready, out_valid, count);
      end
      in_valid = 1'b1; in_result = 32'h12345678; in_flags = 5'b00000;
      cyc();
      in_valid = 1'b0;
      checks++;
      if (count !== 3'd1 || out_result !== 32'h12345678) begin
         errors++;
         $display("FAIL post_reset_push: count=%0d head=%h, expected 1/12345678", count, out_result);
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL post_reset_pop: valid=%b count=%0d, expected 0/0", out_valid, count);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_back_to_back();
      test_exc_count();
      test_sticky();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fp_mul_result_buffer.md
FP_MUL_RESULT_BUFFER -- requirements
Module: fp_mul_result_buffer

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  multiplier output word present.
REQ-005 in_ready  output  1  buffer can accept a word this cycle.
REQ-006 in_result  input  32  IEEE-754 single product from multiplier.
REQ-007 in_flags  input  5  {inf, nan, zero, overflow, underflow} from multiplier.
REQ-008 out_valid  output  1  head entry present.
REQ-009 out_ready  input  1  consumer accepts head entry this cycle.
REQ-010 out_result  output  32  head entry result.
REQ-011 out_flags  output  5  head entry flags, same bit order as in_flags.
REQ-012 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013 exc_count  output  8  count of accepted words with any of nan, inf, overflow or underflow set.
REQ-014 sticky_clr  input  1  synchronous clear of sticky flags.
REQ-015 sticky  output  5  OR of flags of all words accepted since the last clear.

Function
REQ-016 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-017 in_ready is 1 exactly when count < DEPTH; out_valid is 1 exactly when count > 0; both are purely registered-state derived, with no combinational path from in_valid or out_ready.
REQ-018 A pushed word appears at the outputs no earlier than the next cycle; there is no same-cycle bypass when the buffer is empty.
REQ-019 When full, in_ready is 0 and no push occurs even if a pop happens the same cycle.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged and preserves FIFO order.
REQ-021 Read and write pointers wrap modulo DEPTH; ordering is preserved across wrap.
REQ-022 out_result and out_flags are held at 0 while out_valid is 0.
REQ-023 out_result and out_flags are stable while out_valid=1 and out_ready=0.
REQ-024 exc_count increments by 1 on each push with |(in_flags & 5'b11011) = 1 and saturates at 255.
REQ-025 Words are stored unmodified; the block performs no arithmetic on in_result.

Reset
REQ-026 While reset_n=0: count=0, pointers=0, exc_count=0, sticky=0, out_valid=0, in_ready=1, out_result=0, out_flags=0.
REQ-027 Reset asserted mid-operation discards all stored entries immediately; storage contents need not be cleared.
REQ-028 First push is accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-029 Macro FP_STICKY_FLAGS_EN: when defined, sticky |= in_flags on each push, and sticky_clr=1 sets sticky to 0.
REQ-030 With FP_STICKY_FLAGS_EN defined, if sticky_clr and a push occur in the same cycle, sticky takes the pushed word's in_flags.
REQ-031 Without FP_STICKY_FLAGS_EN, sticky is constant 0, sticky_clr is ignored, and no sticky register is implemented.

Verification
REQ-032 Reset, then push 0x40400000 with flags 00000, out_ready=0 -> out_valid=1 next cycle, out_result=0x40400000, count=1, in_ready=1.
REQ-033 Push 4 words A..D with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is not accepted; then out_ready=1 for 4 cycles -> A, B, C, D in order, then out_valid=0, out_result=0.
REQ-034 Hold count=2 and push/pop every cycle for 10 cycles -> count stays 2, order is preserved across pointer wrap, no loss or duplication.
REQ-035 Push 300 words with flags 01000 (nan) -> exc_count=255 (saturated); push a word with flags 00100 (zero) -> exc_count unchanged.
REQ-036 With FP_STICKY_FLAGS_EN: push flags 10000 then 00001 -> sticky=10001; sticky_clr with a simultaneous push of 00010 -> sticky=00010; without the macro sticky=0 throughout.
REQ-037 Assert reset_n=0 with count=3 -> count=0, out_valid=0 asynchronously; after release, in_ready=1 and no old entry reappears.
